// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU opcode constants and controller state encoding
package alu_pkg;

   localparam int SIZEDATA_DEF = 8;
   localparam int SIZEOP_DEF   = 6;

   localparam logic [SIZEOP_DEF-1:0] OP_ADD = 6'b100000;
   localparam logic [SIZEOP_DEF-1:0] OP_SUB = 6'b100010;
   localparam logic [SIZEOP_DEF-1:0] OP_AND = 6'b100100;
   localparam logic [SIZEOP_DEF-1:0] OP_OR  = 6'b100101;
   localparam logic [SIZEOP_DEF-1:0] OP_XOR = 6'b100110;
   localparam logic [SIZEOP_DEF-1:0] OP_NOR = 6'b100111;
   localparam logic [SIZEOP_DEF-1:0] OP_SRL = 6'b000010;
   localparam logic [SIZEOP_DEF-1:0] OP_SRA = 6'b000011;

   typedef enum logic [2:0] {
      S_A       = 3'd0,
      S_B       = 3'd1,
      S_OP      = 3'd2,
      S_EXEC    = 3'd3,
      S_SEND    = 3'd4,
      S_WAIT_TX = 3'd5
   } state_t;

endpackage

// File: rtl/alu_ctrl_timeout.sv
// alu_ctrl_timeout: inter-byte cycle counter; expire flags the cycle whose edge makes the count reach TIMEOUT_CYCLES-1
module alu_ctrl_timeout #(
   parameter int TIMEOUT_CYCLES = 50000000
)(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic expire
);
   localparam int W = $clog2(TIMEOUT_CYCLES);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 2);

   logic [W-1:0] cnt_q, cnt_d;

   // count only while waiting for a byte; any byte or leaving the wait restarts from zero
   always_comb begin
      cnt_d = (clr || !run) ? '0 : cnt_q + W'(1);
   end

   // counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expire = run && cnt_q == LAST;

endmodule

// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: collects A, B, opcode bytes from UART, runs the ALU and sends the result; ALU_CTRL_TIMEOUT_EN adds an inter-byte timeout
module alu_uart_ctrl
   import alu_pkg::*;
#(
   parameter int SIZEDATA       = SIZEDATA_DEF,
   parameter int SIZEOP         = SIZEOP_DEF,
   parameter int TIMEOUT_CYCLES = 50000000
)(
   input  logic                CLK,
   input  logic                RESET,
   input  logic [SIZEDATA-1:0] RX_DATA,
   input  logic                RX_DONE,
   input  logic                TX_DONE,
   input  logic                TX_BUSY,
   input  logic [SIZEDATA-1:0] ALU_RESULT,
   output logic [SIZEDATA-1:0] ALU_A,
   output logic [SIZEDATA-1:0] ALU_B,
   output logic [SIZEOP-1:0]   ALU_OP,
   output logic [SIZEDATA-1:0] TX_DATA,
   output logic                TX_START,
   output logic                BUSY,
   output logic                OVERRUN,
   output logic                ERROR
);
   state_t              state_q, state_d;
   logic [SIZEDATA-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, tx_data_q, tx_data_d;
   logic [SIZEOP-1:0]   alu_op_q, alu_op_d;
   logic                overrun_q, overrun_d, error_q, error_d;
   logic                waiting, expire;

   assign waiting = state_q == S_B || state_q == S_OP;

`ifdef ALU_CTRL_TIMEOUT_EN
   alu_ctrl_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk    (CLK),
      .rst    (RESET),
      .clr    (RX_DONE),
      .run    (waiting),
      .expire (expire)
   );
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign expire = 1'b0;
`endif

   // next-state and next-output logic; a byte arriving with expiry wins over the timeout
   always_comb begin
      state_d   = state_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_op_d  = alu_op_q;
      tx_data_d = tx_data_q;
      overrun_d = RX_DONE && !(state_q == S_A || waiting);
      error_d   = waiting && expire && !RX_DONE;
      case (state_q)
         S_A: if (RX_DONE) begin
            alu_a_d = RX_DATA;
            state_d = S_B;
         end
         S_B: if (RX_DONE) begin
            alu_b_d = RX_DATA;
            state_d = S_OP;
         end else if (expire) state_d = S_A;
         S_OP: if (RX_DONE) begin
            alu_op_d = RX_DATA[SIZEOP-1:0];
            state_d  = S_EXEC;
         end else if (expire) state_d = S_A;
         S_EXEC: begin
            tx_data_d = ALU_RESULT;
            state_d   = S_SEND;
         end
         S_SEND:    state_d = TX_BUSY ? S_SEND : S_WAIT_TX;
         S_WAIT_TX: state_d = TX_DONE ? S_A : S_WAIT_TX;
         default:   state_d = S_A;
      endcase
   end

   // FSM state and registered outputs; reset abandons any partial transaction
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_A;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_op_q  <= '0;
         tx_data_q <= '0;
         overrun_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_op_q  <= alu_op_d;
         tx_data_q <= tx_data_d;
         overrun_q <= overrun_d;
         error_q   <= error_d;
      end
   end

   assign ALU_A    = alu_a_q;
   assign ALU_B    = alu_b_q;
   assign ALU_OP   = alu_op_q;
   assign TX_DATA  = tx_data_q;
   assign OVERRUN  = overrun_q;
   assign ERROR    = error_q;
   assign BUSY     = state_q != S_A;
   assign TX_START = state_q == S_SEND && !TX_BUSY;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// tb_alu_uart_ctrl: directed-vector bench for alu_uart_ctrl with a behavioural ALU; timeout checks follow ALU_CTRL_TIMEOUT_EN
module tb_alu_uart_ctrl;
   import alu_pkg::*;

   logic       CLK = 1'b0, RESET = 1'b1;
   logic [7:0] RX_DATA = '0, ALU_RESULT, ALU_A, ALU_B, TX_DATA;
   logic       RX_DONE = 1'b0, TX_DONE = 1'b0, TX_BUSY = 1'b0;
   logic [5:0] ALU_OP;
   logic       TX_START, BUSY, OVERRUN, ERROR;
   int         n_cmp = 0, n_bad = 0;

   alu_uart_ctrl #(.SIZEDATA(8), .SIZEOP(6), .TIMEOUT_CYCLES(16)) dut (
      .CLK(CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_DONE(RX_DONE),
      .TX_DONE(TX_DONE), .TX_BUSY(TX_BUSY), .ALU_RESULT(ALU_RESULT),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .TX_DATA(TX_DATA),
      .TX_START(TX_START), .BUSY(BUSY), .OVERRUN(OVERRUN), .ERROR(ERROR)
   );

   always #5 CLK = ~CLK;

   // behavioural ALU driven by the controller's registered operands
   always_comb begin
      case (ALU_OP)
         OP_ADD:  ALU_RESULT = ALU_A + ALU_B;
         OP_SUB:  ALU_RESULT = ALU_A - ALU_B;
         OP_AND:  ALU_RESULT = ALU_A & ALU_B;
         OP_OR:   ALU_RESULT = ALU_A | ALU_B;
         OP_XOR:  ALU_RESULT = ALU_A ^ ALU_B;
         OP_NOR:  ALU_RESULT = ~(ALU_A | ALU_B);
         OP_SRL:  ALU_RESULT = ALU_A >> ALU_B;
         OP_SRA:  ALU_RESULT = $unsigned($signed(ALU_A) >>> ALU_B);
         default: ALU_RESULT = 8'h00;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      RX_DATA = b;
      RX_DONE = 1'b1;
      tick();
      RX_DONE = 1'b0;
   endtask

   // full transaction; busy_n = S_SEND cycles with TX_BUSY high, ovr: 0 none, 1 stray byte in S_WAIT_TX, 2 stray byte with TX_DONE
   task automatic txn(input logic [7:0] a, b, opb, res, input int busy_n, input int ovr);
      send_byte(a);
      send_byte(b);
      send_byte(opb);
      chk("exec_a", ALU_A, a);
      chk("exec_b", ALU_B, b);
      chk("exec_op", ALU_OP, opb[5:0]);
      chk("exec_start", TX_START, 0);
      chk("exec_busy", BUSY, 1);
      TX_BUSY = busy_n > 0;
      tick();
      for (int i = 0; i < busy_n; i++) begin
         chk("held_start", TX_START, 0);
         chk("held_data", TX_DATA, res);
         tick();
      end
      TX_BUSY = 1'b0;
      #1;
      chk("send_start", TX_START, 1);
      chk("send_data", TX_DATA, res);
      tick();
      chk("wait_start", TX_START, 0);
      chk("wait_busy", BUSY, 1);
      if (ovr == 1) begin
         RX_DATA = 8'hAA;
         RX_DONE = 1'b1;
         tick();
         RX_DONE = 1'b0;
         chk("ovr_pulse", OVERRUN, 1);
         chk("ovr_busy", BUSY, 1);
         chk("ovr_a", ALU_A, a);
         tick();
         chk("ovr_clear", OVERRUN, 0);
      end
      RX_DATA = 8'hAA;
      RX_DONE = ovr == 2;
      TX_DONE = 1'b1;
      tick();
      TX_DONE = 1'b0;
      RX_DONE = 1'b0;
      chk("done_busy", BUSY, 0);
      chk("done_ovr", OVERRUN, ovr == 2);
      chk("done_a", ALU_A, a);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tick();
      tick();
      chk("rst_a", ALU_A, 0);
      chk("rst_b", ALU_B, 0);
      chk("rst_op", ALU_OP, 0);
      chk("rst_tx", TX_DATA, 0);
      chk("rst_start", TX_START, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_ovr", OVERRUN, 0);
      chk("rst_err", ERROR, 0);
      RESET = 1'b0;
      tick();
      txn(8'h05, 8'h03, 8'h20, 8'h08, 0, 0);
      txn(8'h05, 8'h07, 8'h22, 8'hFE, 0, 0);
      txn(8'hF0, 8'h04, 8'h03, 8'hFF, 0, 0);
      txn(8'h0F, 8'h30, 8'hE7, 8'hC0, 0, 0);
      txn(8'h80, 8'h01, 8'h02, 8'h40, 10, 0);
      txn(8'h33, 8'h0F, 8'h24, 8'h03, 0, 1);
      txn(8'h01, 8'h01, 8'h20, 8'h02, 0, 2);
      txn(8'h06, 8'h03, 8'h26, 8'h05, 0, 0);
      send_byte(8'h11);
      send_byte(8'h22);
      chk("mid_busy", BUSY, 1);
      #2 RESET = 1'b1;
      #1;
      chk("arst_a", ALU_A, 0);
      chk("arst_b", ALU_B, 0);
      chk("arst_busy", BUSY, 0);
      #3 RESET = 1'b0;
      tick();
      chk("post_rst_busy", BUSY, 0);
      txn(8'h0F, 8'hF0, 8'h25, 8'hFF, 0, 0);
      send_byte(8'h5A);
`ifdef ALU_CTRL_TIMEOUT_EN
      for (int i = 0; i < 15; i++) begin
         chk("to_wait_err", ERROR, 0);
         chk("to_wait_busy", BUSY, 1);
         tick();
      end
      chk("to_err", ERROR, 1);
      chk("to_busy", BUSY, 0);
      chk("to_keep_a", ALU_A, 8'h5A);
      tick();
      chk("to_err_clear", ERROR, 0);
`else
      for (int i = 0; i < 20; i++) tick();
      chk("no_to_busy", BUSY, 1);
      chk("no_to_err", ERROR, 0);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      tick();
`endif
      txn(8'h09, 8'h04, 8'h22, 8'h05, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
